// File: rtl/pixel_concat_tb_data_chk_pkg.sv
// Shared constants and types for the pixel_concat stream sink/checker and its stall generator.
package pixel_concat_tb_data_chk_pkg;

  localparam int unsigned MODE_NONE    = 0;
  localparam int unsigned MODE_PATTERN = 1;
  localparam int unsigned MODE_RANDOM  = 2;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting: taps land on bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int unsigned DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/pixel_concat_tb_data_chk_stall_gen.sv
// Backpressure pattern source for stream sinks: free-running counter and LFSR,
// mode-selected into a single stall request.
module tb_stall_gen
  import pixel_concat_tb_data_chk_pkg::*;
#(
  parameter int unsigned MODE = MODE_NONE
) (
  input  logic clk,
  input  logic rst,
  output logic stall_next_o
);

  logic [15:0] scnt_q, scnt_d;
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    scnt_d = scnt_q + 16'd1;
    lfsr_d = {lfsr_feedback(lfsr_q), lfsr_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      scnt_q <= scnt_d;
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    stall_next_o = 1'b0;
    case (MODE)
      MODE_PATTERN: stall_next_o = (scnt_q[2] & scnt_q[4]) | scnt_q[9];
      MODE_RANDOM:  stall_next_o = (lfsr_q[1:0] == 2'b00);
      default:      stall_next_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pixel_concat_tb_data_chk.sv
// Stream sink for the pixel_concat benches: accepts every valid word, checks it
// against an incrementing sequence, drives advisory backpressure, reports a verdict.
module pixel_concat_tb_data_chk
  import pixel_concat_tb_data_chk_pkg::*;
#(
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned MODE      = MODE_NONE,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned START     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DAT_WIDTH-1:0] idat,
  input  logic                 ival,
  output logic                 ostall,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_cnt,
  output logic [DAT_WIDTH-1:0] rcv_cnt,
  output logic [7:0]           skid_cnt,
  output logic [DAT_WIDTH-1:0] first_err_exp,
  output logic [DAT_WIDTH-1:0] first_err_got
);

  localparam logic [DAT_WIDTH-1:0] START_W    = DAT_WIDTH'(START);
  localparam logic [DAT_WIDTH-1:0] NUM_W      = DAT_WIDTH'(NUM_WORDS);
  localparam logic [DAT_WIDTH-1:0] LAST_W     = DAT_WIDTH'(NUM_WORDS - 1);
  localparam logic [DAT_WIDTH-1:0] ONE_W      = DAT_WIDTH'(1);
  localparam logic                 DRAIN_LAST = 1'(DRAIN_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 drain_q, drain_d;
  logic [DAT_WIDTH-1:0] exp_q, exp_d;
  logic [DAT_WIDTH-1:0] rcv_q, rcv_d;
  logic [15:0]          err_q, err_d;
  logic [7:0]           skid_q, skid_d;
  logic [DAT_WIDTH-1:0] fexp_q, fexp_d;
  logic [DAT_WIDTH-1:0] fgot_q, fgot_d;
  logic                 ostall_q, ostall_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 stall_next;

  tb_stall_gen #(.MODE(MODE)) u_stall (
    .clk          (clk),
    .rst          (rst),
    .stall_next_o (stall_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (ival && (rcv_q == LAST_W)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          drain_d = 1'b0;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    exp_d    = exp_q;
    rcv_d    = rcv_q;
    err_d    = err_q;
    skid_d   = skid_q;
    fexp_d   = fexp_q;
    fgot_d   = fgot_q;
    ostall_d = 1'b1;
    unique case (state_q)
      ST_RUN: begin
        ostall_d = stall_next;
        if (ival) begin
          rcv_d = rcv_q + ONE_W;
          if (idat != exp_q) begin
            if (err_q != '1) err_d = err_q + 16'd1;
            if (err_q == '0) begin
              fexp_d = exp_q;
              fgot_d = idat;
            end
            // resync so one dropped word costs exactly one error
            exp_d = idat + ONE_W;
          end else begin
            exp_d = exp_q + ONE_W;
          end
        end
        if (state_d == ST_DRAIN) ostall_d = 1'b1;
      end
      default: begin
        if (ival && (skid_q != '1)) skid_d = skid_q + 8'd1;
      end
    endcase
    done_d = (state_d == ST_DONE);
    pass_d = (state_d == ST_DONE) && (err_q == '0) && (rcv_q == NUM_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q    <= START_W;
      rcv_q    <= '0;
      err_q    <= '0;
      skid_q   <= '0;
      fexp_q   <= '0;
      fgot_q   <= '0;
      ostall_q <= 1'b1;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      exp_q    <= exp_d;
      rcv_q    <= rcv_d;
      err_q    <= err_d;
      skid_q   <= skid_d;
      fexp_q   <= fexp_d;
      fgot_q   <= fgot_d;
      ostall_q <= ostall_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign ostall        = ostall_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign rcv_cnt       = rcv_q;
  assign skid_cnt      = skid_q;
  assign first_err_exp = fexp_q;
  assign first_err_got = fgot_q;

endmodule

// File: tb/tb_pixel_concat_tb_data_chk.sv
// Self-checking bench for pixel_concat_tb_data_chk: directed and randomized word
// streams against a sequence-level reference model, plus stall-pattern checks.
module tb_pixel_concat_tb_data_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // A: 32-bit, no stall, 8 words from 1
  logic        rst_a = 1'b1, ival_a = 1'b0;
  logic [31:0] idat_a = '0;
  logic        ostall_a, done_a, pass_a;
  logic [15:0] err_a;
  logic [31:0] rcv_a, fexp_a, fgot_a;
  logic [7:0]  skid_a;
  pixel_concat_tb_data_chk #(.DAT_WIDTH(32), .MODE(0), .NUM_WORDS(8), .START(1)) u_a (
    .clk(clk), .rst(rst_a), .idat(idat_a), .ival(ival_a), .ostall(ostall_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .rcv_cnt(rcv_a), .skid_cnt(skid_a),
    .first_err_exp(fexp_a), .first_err_got(fgot_a));

  // W: 8-bit wrap-around
  logic        rst_w = 1'b1, ival_w = 1'b0;
  logic [7:0]  idat_w = '0;
  logic        ostall_w, done_w, pass_w;
  logic [15:0] err_w;
  logic [7:0]  rcv_w, fexp_w, fgot_w, skid_w;
  pixel_concat_tb_data_chk #(.DAT_WIDTH(8), .MODE(0), .NUM_WORDS(4), .START(254)) u_w (
    .clk(clk), .rst(rst_w), .idat(idat_w), .ival(ival_w), .ostall(ostall_w), .done(done_w),
    .pass(pass_w), .err_cnt(err_w), .rcv_cnt(rcv_w), .skid_cnt(skid_w),
    .first_err_exp(fexp_w), .first_err_got(fgot_w));

  // P: counter stall pattern, never fed
  logic        rst_p = 1'b1, ival_p = 1'b0;
  logic [31:0] idat_p = '0;
  logic        ostall_p, done_p, pass_p;
  logic [15:0] err_p;
  logic [31:0] rcv_p, fexp_p, fgot_p;
  logic [7:0]  skid_p;
  pixel_concat_tb_data_chk #(.DAT_WIDTH(32), .MODE(1), .NUM_WORDS(4096), .START(1)) u_p (
    .clk(clk), .rst(rst_p), .idat(idat_p), .ival(ival_p), .ostall(ostall_p), .done(done_p),
    .pass(pass_p), .err_cnt(err_p), .rcv_cnt(rcv_p), .skid_cnt(skid_p),
    .first_err_exp(fexp_p), .first_err_got(fgot_p));

  // R: LFSR stall pattern, fed by a stall-respecting source
  logic        rst_r = 1'b1, ival_r = 1'b0;
  logic [31:0] idat_r = '0;
  logic        ostall_r, done_r, pass_r;
  logic [15:0] err_r;
  logic [31:0] rcv_r, fexp_r, fgot_r;
  logic [7:0]  skid_r;
  pixel_concat_tb_data_chk #(.DAT_WIDTH(32), .MODE(2), .NUM_WORDS(1000), .START(1)) u_r (
    .clk(clk), .rst(rst_r), .idat(idat_r), .ival(ival_r), .ostall(ostall_r), .done(done_r),
    .pass(pass_r), .err_cnt(err_r), .rcv_cnt(rcv_r), .skid_cnt(skid_r),
    .first_err_exp(fexp_r), .first_err_got(fgot_r));

  logic [31:0] stim [16];
  int unsigned m_err;
  logic [31:0] m_fexp, m_fgot;
  int unsigned a_ost_bad;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sequence-level reference: compare each word to the running expectation, resync on error
  task automatic model_a(input int n);
    logic [31:0] e;
    e = 32'd1;
    m_err = 0; m_fexp = '0; m_fgot = '0;
    for (int i = 0; i < n; i++) begin
      if (stim[i] != e) begin
        if (m_err == 0) begin m_fexp = e; m_fgot = stim[i]; end
        m_err++;
      end
      e = stim[i] + 32'd1;
    end
  endtask

  task automatic reset_a;
    rst_a = 1'b1; ival_a = 1'b0;
    tick(); tick();
    rst_a = 1'b0;
  endtask

  task automatic drive_a(input int n, input bit gaps);
    a_ost_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          ival_a = 1'b0; tick();
          if (ostall_a !== 1'b0) a_ost_bad++;
        end
      end
      ival_a = 1'b1; idat_a = stim[i]; tick();
      if (ostall_a !== 1'(i == n - 1)) a_ost_bad++;
    end
    ival_a = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  task automatic test_reset;
    reset_a();
    n_cmp++; if (ostall_a !== 1'b1) begin n_bad++; $display("FAIL reset_ostall: got %b want 1", ostall_a); end
    n_cmp++; if (done_a !== 1'b0 || pass_a !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got done=%b pass=%b want 0/0", done_a, pass_a); end
    n_cmp++; if (err_a !== 16'd0 || rcv_a !== 32'd0 || skid_a !== 8'd0) begin n_bad++;
      $display("FAIL reset_counts: got err=%0d rcv=%0d skid=%0d want 0/0/0", err_a, rcv_a, skid_a); end
    n_cmp++; if (fexp_a !== 32'd0 || fgot_a !== 32'd0) begin n_bad++; $display("FAIL reset_first: got %0d/%0d want 0/0", fexp_a, fgot_a); end
  endtask

  task automatic test_clean;
    for (int i = 0; i < 8; i++) stim[i] = 32'(i + 1);
    reset_a();
    drive_a(8, 1'b0);
    n_cmp++; if (a_ost_bad != 0) begin n_bad++; $display("FAIL clean_ostall: got %0d bad cycles want 0", a_ost_bad); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL clean_done_e0: got %b want 0", done_a); end
    tick();
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL clean_done_e1: got %b want 0", done_a); end
    tick();
    n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL clean_done_e2: got %b want 1", done_a); end
    n_cmp++; if (pass_a !== 1'b1) begin n_bad++; $display("FAIL clean_pass: got %b want 1", pass_a); end
    n_cmp++; if (err_a !== 16'd0 || rcv_a !== 32'd8) begin n_bad++; $display("FAIL clean_counts: got err=%0d rcv=%0d want 0/8", err_a, rcv_a); end
    n_cmp++; if (ostall_a !== 1'b1) begin n_bad++; $display("FAIL clean_ostall_done: got %b want 1", ostall_a); end
  endtask

  task automatic run_error_case(input string name, input logic [31:0] w [8], input bit gaps);
    for (int i = 0; i < 8; i++) stim[i] = w[i];
    model_a(8);
    reset_a();
    drive_a(8, gaps);
    tick(); tick();
    n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %b want 1", name, done_a); end
    n_cmp++; if (err_a !== 16'(m_err)) begin n_bad++; $display("FAIL %s_err: got %0d want %0d", name, err_a, m_err); end
    n_cmp++; if (fexp_a !== m_fexp || fgot_a !== m_fgot) begin n_bad++;
      $display("FAIL %s_first: got exp=%0d got=%0d want exp=%0d got=%0d", name, fexp_a, fgot_a, m_fexp, m_fgot); end
    n_cmp++; if (pass_a !== 1'(m_err == 0) || rcv_a !== 32'd8) begin n_bad++;
      $display("FAIL %s_verdict: got pass=%b rcv=%0d want pass=%b rcv=8", name, pass_a, rcv_a, m_err == 0); end
  endtask

  task automatic test_dropped;
    logic [31:0] w [8] = '{1, 2, 3, 5, 6, 7, 8, 9};
    run_error_case("drop", w, 1'b0);
    n_cmp++; if (err_a !== 16'd1 || fexp_a !== 32'd4 || fgot_a !== 32'd5 || pass_a !== 1'b0) begin n_bad++;
      $display("FAIL drop_fixed: got err=%0d exp=%0d got=%0d pass=%b want 1/4/5/0", err_a, fexp_a, fgot_a, pass_a); end
  endtask

  task automatic test_corrupted;
    logic [31:0] w [8] = '{1, 2, 3, 4, 9, 6, 7, 8};
    run_error_case("corrupt", w, 1'b0);
    n_cmp++; if (err_a !== 16'd2 || fexp_a !== 32'd5 || fgot_a !== 32'd9) begin n_bad++;
      $display("FAIL corrupt_fixed: got err=%0d exp=%0d got=%0d want 2/5/9", err_a, fexp_a, fgot_a); end
  endtask

  task automatic test_random_seq;
    logic [31:0] w [8];
    logic [31:0] v;
    for (int it = 0; it < 8; it++) begin
      v = 32'd1;
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(7))
          0: begin w[i] = v + 32'd1; v = v + 32'd2; end
          1: begin w[i] = $urandom; v = v + 32'd1; end
          default: begin w[i] = v; v = v + 32'd1; end
        endcase
      end
      run_error_case("rand", w, 1'b1);
    end
  endtask

  task automatic test_skid;
    for (int i = 0; i < 8; i++) stim[i] = 32'(i + 1);
    reset_a();
    drive_a(8, 1'b1);
    ival_a = 1'b1;
    for (int i = 0; i < 5; i++) begin idat_a = $urandom; tick(); end
    n_cmp++; if (skid_a !== 8'd5) begin n_bad++; $display("FAIL skid_cnt: got %0d want 5", skid_a); end
    n_cmp++; if (rcv_a !== 32'd8 || err_a !== 16'd0) begin n_bad++; $display("FAIL skid_counts: got rcv=%0d err=%0d want 8/0", rcv_a, err_a); end
    n_cmp++; if (done_a !== 1'b1 || pass_a !== 1'b1) begin n_bad++; $display("FAIL skid_verdict: got done=%b pass=%b want 1/1", done_a, pass_a); end
    for (int i = 0; i < 300; i++) begin idat_a = $urandom; tick(); end
    ival_a = 1'b0;
    n_cmp++; if (skid_a !== 8'd255) begin n_bad++; $display("FAIL skid_sat: got %0d want 255", skid_a); end
  endtask

  task automatic test_wrap;
    logic [7:0] seqs [2][4] = '{'{8'd254, 8'd255, 8'd0, 8'd1}, '{8'd254, 8'd0, 8'd1, 8'd2}};
    logic [7:0] e;
    int unsigned me;
    logic [7:0] mfe, mfg;
    for (int s = 0; s < 2; s++) begin
      rst_w = 1'b1; ival_w = 1'b0; tick(); tick(); rst_w = 1'b0;
      e = 8'd254; me = 0; mfe = '0; mfg = '0;
      for (int i = 0; i < 4; i++) begin
        if (seqs[s][i] != e) begin if (me == 0) begin mfe = e; mfg = seqs[s][i]; end me++; end
        e = seqs[s][i] + 8'd1;
        ival_w = 1'b1; idat_w = seqs[s][i]; tick();
      end
      ival_w = 1'b0;
      tick(); tick();
      n_cmp++; if (done_w !== 1'b1 || rcv_w !== 8'd4) begin n_bad++; $display("FAIL wrap%0d_done: got done=%b rcv=%0d want 1/4", s, done_w, rcv_w); end
      n_cmp++; if (err_w !== 16'(me) || pass_w !== 1'(me == 0)) begin n_bad++;
        $display("FAIL wrap%0d_verdict: got err=%0d pass=%b want %0d/%b", s, err_w, pass_w, me, me == 0); end
      n_cmp++; if (fexp_w !== mfe || fgot_w !== mfg) begin n_bad++;
        $display("FAIL wrap%0d_first: got %0d/%0d want %0d/%0d", s, fexp_w, fgot_w, mfe, mfg); end
    end
  endtask

  task automatic test_pattern;
    int unsigned bad, first_bad;
    logic want;
    rst_p = 1'b1; tick(); tick(); rst_p = 1'b0;
    n_cmp++; if (ostall_p !== 1'b1) begin n_bad++; $display("FAIL pattern_reset: got %b want 1", ostall_p); end
    bad = 0; first_bad = 0;
    for (int n = 1; n <= 1200; n++) begin
      tick();
      want = 1'((((n - 1) >> 2) & ((n - 1) >> 4) & 1) | (((n - 1) >> 9) & 1));
      if (ostall_p !== want) begin if (bad == 0) first_bad = n; bad++; end
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL pattern_ostall: got %0d bad cycles (first at edge %0d) want 0", bad, first_bad); end
  endtask

  task automatic test_generator;
    int unsigned acc, run_cyc, stall_cyc, ost_bad, cyc;
    logic [15:0] ml;
    logic [31:0] nxt;
    logic want;
    bit did_rst;
    rst_r = 1'b1; ival_r = 1'b0; tick(); tick(); rst_r = 1'b0;
    ml = 16'hACE1; acc = 0; nxt = 32'd1; did_rst = 1'b0;
    run_cyc = 0; stall_cyc = 0; ost_bad = 0; cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      ival_r = !ostall_r && ($urandom_range(9) != 0);
      idat_r = nxt;
      tick(); cyc++;
      if (ival_r) begin acc++; nxt++; end
      want = (acc == 1000) ? 1'b1 : (ml[1:0] == 2'b00);
      ml = lfsr_next(ml);
      if (ostall_r !== want) ost_bad++;
      if (acc < 1000) begin run_cyc++; if (ostall_r) stall_cyc++; end
      if (!did_rst && acc == 500) begin
        n_cmp++; if (rcv_r !== 32'd500) begin n_bad++; $display("FAIL gen_mid_rcv: got %0d want 500", rcv_r); end
        rst_r = 1'b1; ival_r = 1'b0; tick(); rst_r = 1'b0;
        n_cmp++; if (rcv_r !== 32'd0 || err_r !== 16'd0 || skid_r !== 8'd0) begin n_bad++;
          $display("FAIL gen_rst_counts: got rcv=%0d err=%0d skid=%0d want 0/0/0", rcv_r, err_r, skid_r); end
        n_cmp++; if (ostall_r !== 1'b1 || done_r !== 1'b0 || pass_r !== 1'b0) begin n_bad++;
          $display("FAIL gen_rst_flags: got ostall=%b done=%b pass=%b want 1/0/0", ostall_r, done_r, pass_r); end
        ml = 16'hACE1; acc = 0; nxt = 32'd1; did_rst = 1'b1;
      end
    end
    ival_r = 1'b0;
    n_cmp++; if (acc < 1000) begin n_bad++; $display("FAIL gen_timeout: got %0d words want 1000", acc); end
    tick(); tick();
    n_cmp++; if (done_r !== 1'b1 || pass_r !== 1'b1) begin n_bad++; $display("FAIL gen_verdict: got done=%b pass=%b want 1/1", done_r, pass_r); end
    n_cmp++; if (rcv_r !== 32'd1000 || err_r !== 16'd0) begin n_bad++; $display("FAIL gen_counts: got rcv=%0d err=%0d want 1000/0", rcv_r, err_r); end
    n_cmp++; if (ost_bad != 0) begin n_bad++; $display("FAIL gen_ostall: got %0d bad cycles want 0", ost_bad); end
    n_cmp++; if (stall_cyc * 100 < run_cyc * 20 || stall_cyc * 100 > run_cyc * 30) begin n_bad++;
      $display("FAIL gen_duty: got %0d of %0d stalled want 20-30%%", stall_cyc, run_cyc); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_dropped();
    test_corrupted();
    test_random_seq();
    test_skid();
    test_wrap();
    test_pattern();
    test_generator();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
